// File: rtl/aes_pio_sequencer.sv
// HPS PIO <-> AES core sequencer: four-phase req/ack with software, key-schedule
// caching, core start/completion tracking, abort and timeout recovery.
module aes_pio_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic         clk_clk,
  input  logic         reset_reset_n,
  input  logic [7:0]   hps_control_i,
  input  logic [31:0]  hps_key_0_i,
  input  logic [31:0]  hps_key_1_i,
  input  logic [31:0]  hps_key_2_i,
  input  logic [31:0]  hps_key_3_i,
  input  logic [31:0]  hps_data_0_i,
  input  logic [31:0]  hps_data_1_i,
  input  logic [31:0]  hps_data_2_i,
  input  logic [31:0]  hps_data_3_i,
  output logic         fpga_control_o,
  output logic [31:0]  fpga_data_0_o,
  output logic [31:0]  fpga_data_1_o,
  output logic [31:0]  fpga_data_2_o,
  output logic [31:0]  fpga_data_3_o,
  output logic [3:0]   status_o,
  output logic [127:0] aes_key_o,
  output logic         aes_key_load_o,
  input  logic         aes_key_ready_i,
  output logic [127:0] aes_din_o,
  output logic         aes_decrypt_o,
  output logic         aes_start_o,
  input  logic         aes_done_i,
  input  logic [127:0] aes_dout_i
);
  typedef enum logic [2:0] {
    S_IDLE, S_CAPTURE, S_KEY_LOAD, S_KEY_WAIT, S_START, S_RUN_WAIT, S_ACK
  } state_t;

  // Captured request: key, block and mode travel together.
  typedef struct packed {
    logic [127:0] key;
    logic [127:0] din;
    logic         dec;
  } op_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t       state_q, state_d;
  op_t          op_q, op_d;
  logic [127:0] cache_q, cache_d;
  logic [127:0] data_q, data_d;
  logic [15:0]  timer_q, timer_d;
  logic         req_q, key_valid_q, key_valid_d;
  logic         err_q, err_d, tmo_q, tmo_d;

  logic [127:0] hps_key, hps_din;
  logic         req_rise, abort, reload, expired;
  logic         unused_ctrl;

  assign hps_key     = {hps_key_0_i, hps_key_1_i, hps_key_2_i, hps_key_3_i};
  assign hps_din     = {hps_data_0_i, hps_data_1_i, hps_data_2_i, hps_data_3_i};
  assign req_rise    = hps_control_i[0] & ~req_q;
  assign abort       = hps_control_i[7];
  assign reload      = ~key_valid_q | hps_control_i[2] | (hps_key != cache_q);
  // Timer reads 0 in KEY_LOAD/START and counts every cycle after, so expiry
  // lands the ACK exactly TIMEOUT_CYCLES cycles after the load/start pulse.
  assign expired     = (timer_q == TMO_LAST);
  assign unused_ctrl = ^hps_control_i[6:3];

  // State and datapath registers; every output resets to zero.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      cache_q     <= '0;
      data_q      <= '0;
      timer_q     <= '0;
      req_q       <= 1'b0;
      key_valid_q <= 1'b0;
      err_q       <= 1'b0;
      tmo_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      cache_q     <= cache_d;
      data_q      <= data_d;
      timer_q     <= timer_d;
      req_q       <= hps_control_i[0];
      key_valid_q <= key_valid_d;
      err_q       <= err_d;
      tmo_q       <= tmo_d;
    end
  end

  // Next-state and datapath updates; abort beats completion, completion beats timeout.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    cache_d     = cache_q;
    data_d      = data_q;
    timer_d     = timer_q;
    key_valid_d = key_valid_q;
    err_d       = err_q;
    tmo_d       = tmo_q;
    unique case (state_q)
      S_IDLE: if (req_rise) state_d = S_CAPTURE;
      S_CAPTURE: begin
        op_d    = '{key: hps_key, din: hps_din, dec: hps_control_i[1]};
        err_d   = 1'b0;
        timer_d = '0;
        if (abort) begin
          state_d = S_ACK; err_d = 1'b1; data_d = '0;
        end else if (reload) state_d = S_KEY_LOAD;
        else state_d = S_START;
      end
      S_KEY_LOAD: begin
        key_valid_d = 1'b0;
        timer_d     = timer_q + 16'd1;
        if (abort) begin
          state_d = S_ACK; err_d = 1'b1; data_d = '0;
        end else state_d = S_KEY_WAIT;
      end
      S_KEY_WAIT: begin
        timer_d = timer_q + 16'd1;
        if (abort) begin
          state_d = S_ACK; err_d = 1'b1; data_d = '0; key_valid_d = 1'b0;
        end else if (aes_key_ready_i) begin
          state_d = S_START; cache_d = op_q.key; key_valid_d = 1'b1; timer_d = '0;
        end else if (expired) begin
          state_d = S_ACK; err_d = 1'b1; tmo_d = 1'b1; data_d = '0; key_valid_d = 1'b0;
        end
      end
      S_START: begin
        timer_d = timer_q + 16'd1;
        if (abort) begin
          state_d = S_ACK; err_d = 1'b1; data_d = '0;
        end else state_d = S_RUN_WAIT;
      end
      S_RUN_WAIT: begin
        timer_d = timer_q + 16'd1;
        if (abort) begin
          state_d = S_ACK; err_d = 1'b1; data_d = '0;
        end else if (aes_done_i) begin
          state_d = S_ACK; data_d = aes_dout_i;
        end else if (expired) begin
          state_d = S_ACK; err_d = 1'b1; tmo_d = 1'b1; data_d = '0; key_valid_d = 1'b0;
        end
      end
      S_ACK: if (!hps_control_i[0]) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign fpga_control_o = (state_q == S_ACK);
  assign aes_key_load_o = (state_q == S_KEY_LOAD);
  assign aes_start_o    = (state_q == S_START);
  assign aes_key_o      = op_q.key;
  assign aes_din_o      = op_q.din;
  assign aes_decrypt_o  = op_q.dec;
  assign {fpga_data_0_o, fpga_data_1_o, fpga_data_2_o, fpga_data_3_o} = data_q;
  assign status_o = {tmo_q, key_valid_q, err_q,
                     (state_q != S_IDLE) && (state_q != S_ACK)};
endmodule
